// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Turns the PLL `locked` indication into a clean, registered
//               reset for logic running on the PLL output clock. `locked` is
//               synchronised and must stay high for a qualification interval
//               before reset is released. A loss of lock from RUN re-asserts
//               reset for a minimum hold time. It also sets a sticky flag and
//               bumps a saturating event counter.
// Ports       : clk          - PLL output clock (rising edge)
//               reset        - synchronous active-high reset
//               locked       - raw PLL lock, asynchronous to clk
//               clr          - one-cycle pulse, clears lost_count/lost_sticky
//               sys_rst      - registered downstream reset, active high
//               ready        - registered, high only in RUN (== ~sys_rst)
//               lost_sticky  - set on any loss of lock from RUN
//               lost_count   - saturating count of losses from RUN
//               state        - debug: WAIT_LOCK=0 STABILIZE=1 RUN=2 LOST=3
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES   = 16,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             locked,
   input  logic             clr,
   output logic             sys_rst,
   output logic             ready,
   output logic             lost_sticky,
   output logic [CNT_W-1:0] lost_count,
   output logic [1:0]       state
);

   // One counter is shared by the qualification and hold phases, so it is
   // sized for the longer of the two.
   localparam int C_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int C_CW  = (C_MAX > 1) ? $clog2(C_MAX) : 1;

   localparam logic [C_CW-1:0] C_STABLE_LAST = C_CW'(STABLE_CYCLES - 1);
   localparam logic [C_CW-1:0] C_HOLD_LAST   = C_CW'(HOLD_CYCLES - 1);

   localparam logic [1:0] S_WAIT_LOCK = 2'd0;
   localparam logic [1:0] S_STABILIZE = 2'd1;
   localparam logic [1:0] S_RUN       = 2'd2;
   localparam logic [1:0] S_LOST      = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic [1:0]             state_q, state_d;
   logic [C_CW-1:0]        cnt_q, cnt_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   ready_q, ready_d;
   logic                   sticky_q, sticky_d;
   logic [CNT_W-1:0]       lcnt_q, lcnt_d;
   logic [CNT_W-1:0]       lcnt_base;
   logic                   lost_event;

   // Only the last synchroniser stage is ever consumed.
   assign locked_s   = sync_q[SYNC_STAGES-1];
   assign lost_event = (state_q == S_RUN) && !locked_s;

   // ------------------------------------------------------------------------
   // State register (plus synchroniser, counter and registered outputs)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         state_q   <= S_WAIT_LOCK;
         cnt_q     <= '0;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         sticky_q  <= 1'b0;
         lcnt_q    <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], locked};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         sticky_q  <= sticky_d;
         lcnt_q    <= lcnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_s) begin
               state_d = S_STABILIZE;
            end
         end
         S_STABILIZE: begin
            if (!locked_s) begin
               // Glitch during qualification: start over, not a lock loss.
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == C_STABLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_CW'(1);
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!locked_s) begin
               state_d = S_LOST;
            end
         end
         default: begin
            // LOST: hold time runs out regardless of locked_s.
            if (cnt_q == C_HOLD_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_CW'(1);
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic (registered from the next state)
   // ------------------------------------------------------------------------
   always_comb begin
      sys_rst_d = (state_d != S_RUN);
      ready_d   = (state_d == S_RUN);

      // A clear is applied before a coincident loss event is counted.
      lcnt_base = clr ? '0 : lcnt_q;
      sticky_d  = clr ? 1'b0 : sticky_q;
      lcnt_d    = lcnt_base;
      if (lost_event) begin
         sticky_d = 1'b1;
         if (lcnt_base != {CNT_W{1'b1}}) begin
            lcnt_d = lcnt_base + CNT_W'(1);
         end
      end
   end

   assign sys_rst     = sys_rst_q;
   assign ready       = ready_q;
   assign lost_sticky = sticky_q;
   assign lost_count  = lcnt_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumes the PLL `locked` output and turns it into a clean system reset for the logic clocked by the PLL output clock. It synchronises `locked` and requires a stable-lock interval before releasing reset. On loss of lock it re-asserts reset for a minimum hold time, counts the event and sets a sticky flag. It sits between the PLL instance and every core-domain reset consumer.

Parameters:
SYNC_STAGES, 2, flops in the `locked` synchroniser chain; legal values are 2 or more.
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before reset is released; legal values are 1 or more.
HOLD_CYCLES, 16, minimum number of cycles reset stays asserted after a loss of lock; legal values are 1 or more.
CNT_W, 8, width of the lock-loss event counter.

Ports:
clk  input  1  PLL output clock; all logic runs on the rising edge of this one clock.
reset  input  1  synchronous, active-high reset.
locked  input  1  PLL lock indicator; asynchronous to clk; must pass through the synchroniser before any use.
clr  input  1  one-cycle pulse; clears lost_count and lost_sticky.
sys_rst  output  1  registered reset for downstream logic, active high.
ready  output  1  registered; high only in the RUN state; always equal to ~sys_rst.
lost_sticky  output  1  set on any loss of lock from RUN.
lost_count  output  CNT_W  saturating count of lock losses from RUN.
state  output  2  debug encoding: WAIT_LOCK=0, STABILIZE=1, RUN=2, LOST=3.

Behaviour:
- Reset: state=WAIT_LOCK; synchroniser flops=0; counter=0; sys_rst=1; ready=0; lost_sticky=0; lost_count=0.
- Synchroniser: a chain of SYNC_STAGES flops. locked_s is the last stage. No other logic reads raw `locked`.
- One shared down-counter or up-counter is sized for max(STABLE_CYCLES, HOLD_CYCLES).
- WAIT_LOCK:
  - Counter held at 0.
  - If locked_s=1, go to STABILIZE and set counter=0.
- STABILIZE:
  - If locked_s=0, return to WAIT_LOCK. This is a glitch: no count, no sticky.
  - Otherwise counter increments.
  - When locked_s=1 and counter==STABLE_CYCLES-1, go to RUN.
- RUN:
  - If locked_s=0, go to LOST, set counter=0, set lost_sticky=1, and increment lost_count.
  - lost_count saturates at 2^CNT_W-1 and never wraps.
- LOST:
  - Counter increments regardless of locked_s.
  - When counter==HOLD_CYCLES-1, go to WAIT_LOCK.
  - Lock returning during LOST does not shorten the hold.
- sys_rst and ready are registered from the next state. They change on the same edge the state register changes. sys_rst=0 iff state==RUN.
- Latency:
  - `locked` first sampled high at edge 1 with no drop: state=RUN and ready=1 after edge SYNC_STAGES+STABLE_CYCLES+1.
  - locked_s falling in RUN: sys_rst=1 on the next edge.
  - Loss to earliest possible re-release: HOLD_CYCLES + 1 + STABLE_CYCLES + SYNC-chain refill.
- clr:
  - Clears lost_count to 0 and lost_sticky to 0.
  - If clr coincides with a RUN→LOST transition, clear is applied first and then the event: lost_count=1, lost_sticky=1.
- A mid-operation `reset` from any state returns to reset values on the next edge. Counter and synchroniser are both cleared, so a re-qualification is required even if `locked` is steady high.
- `locked` stuck at 0: remain in WAIT_LOCK with sys_rst=1 indefinitely, with no counting.

Test Plan:
- Assert reset, then release it with locked=1 constant (SYNC_STAGES=2, STABLE_CYCLES=16, HOLD_CYCLES=4) -> sys_rst=1 and state cycles 0→1→2; ready rises exactly 19 edges after the first edge sampling locked=1; lost_count=0.
- In STABILIZE at counter=10, drop locked for 3 cycles -> return to WAIT_LOCK, lost_sticky=0, lost_count=0; after locked returns, the full 16-cycle qualification restarts.
- In RUN, drop locked for 1 cycle -> sys_rst=1 within SYNC_STAGES+1 edges, state=LOST for exactly 4 cycles, lost_count=1, lost_sticky=1; then WAIT_LOCK and a re-qualification of 16 cycles.
- Drive 300 RUN→LOST events with CNT_W=8 -> lost_count saturates at 255; a clr pulse then gives 0.
- Pulse clr on the same edge as a RUN→LOST transition -> lost_count=1, lost_sticky=1.
- Assert reset for 1 cycle while in RUN with locked=1 -> sys_rst=1 and ready=0 next edge, lost_count=0; ready returns after 19 edges.
